// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer between N_REQ byte sources.
// Define UART_ARB_TAG_EN to precede every data byte with a header frame {5'b10100, source id}.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk_50M,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_data_byte,
    output logic               o_data_avail,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic [2:0]         o_grant_id,
    output logic               o_active,
    output logic               o_timeout
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {IDLE, ISSUE_HDR, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    state_t           state, state_nx;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_nx;
    logic [N_REQ-1:0] req_ready_nx;
    logic [7:0]       data_byte_nx;
    logic             data_avail_nx;
    logic [2:0]       grant_id_nx;
    logic             active_nx;
    logic             timeout_nx;
    logic [IDX_W-1:0] winner;
    logic             winner_found;
`ifdef UART_ARB_TAG_EN
    logic [7:0]       held_byte, held_byte_nx;
    logic             hdr_phase, hdr_phase_nx;
`endif

    // First valid source at or above the pointer, wrapping around.
    always_comb begin
        winner_found = 1'b0;
        winner       = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!winner_found && i_req_valid[IDX_W'((int'(rr_ptr) + i) % N_REQ)]) begin
                winner_found = 1'b1;
                winner       = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_nx      = state;
        rr_ptr_nx     = rr_ptr;
        busy_cnt_nx   = busy_cnt;
        req_ready_nx  = '0;
        data_byte_nx  = o_data_byte;
        data_avail_nx = 1'b0;
        grant_id_nx   = o_grant_id;
        active_nx     = o_active;
        timeout_nx    = 1'b0;
`ifdef UART_ARB_TAG_EN
        held_byte_nx  = held_byte;
        hdr_phase_nx  = hdr_phase;
`endif
        case (state)
            IDLE: begin
                // A frame still running after a reset must finish before a new grant.
                if (winner_found && !i_tx_busy) begin
                    req_ready_nx[winner] = 1'b1;
                    grant_id_nx          = 3'(winner);
                    active_nx            = 1'b1;
                    rr_ptr_nx            = (winner == LAST_IDX) ? '0 : winner + 1'b1;
`ifdef UART_ARB_TAG_EN
                    data_byte_nx         = {5'b10100, 3'(winner)};
                    held_byte_nx         = i_req_data[8*int'(winner) +: 8];
                    hdr_phase_nx         = 1'b1;
                    state_nx             = ISSUE_HDR;
`else
                    data_byte_nx         = i_req_data[8*int'(winner) +: 8];
                    state_nx             = ISSUE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ISSUE_HDR, ISSUE: begin
`else
            ISSUE: begin
`endif
                data_avail_nx = 1'b1;
                busy_cnt_nx   = '0;
                state_nx      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_nx = WAIT_DONE;
                end else begin
                    busy_cnt_nx = busy_cnt + 1'b1;
                    if (busy_cnt == CNT_LAST) begin
                        timeout_nx = 1'b1;
                        active_nx  = 1'b0;
                        state_nx   = IDLE;
`ifdef UART_ARB_TAG_EN
                        hdr_phase_nx = 1'b0;
`endif
                    end
                end
            end
            WAIT_DONE: begin
                if (i_tx_done || !i_tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    if (hdr_phase) begin
                        hdr_phase_nx = 1'b0;
                        data_byte_nx = held_byte;
                        state_nx     = ISSUE;
                    end else begin
                        active_nx = 1'b0;
                        state_nx  = IDLE;
                    end
`else
                    active_nx = 1'b0;
                    state_nx  = IDLE;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (i_rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            busy_cnt     <= '0;
            o_req_ready  <= '0;
            o_data_byte  <= '0;
            o_data_avail <= 1'b0;
            o_grant_id   <= '0;
            o_active     <= 1'b0;
            o_timeout    <= 1'b0;
`ifdef UART_ARB_TAG_EN
            held_byte    <= '0;
            hdr_phase    <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            rr_ptr       <= rr_ptr_nx;
            busy_cnt     <= busy_cnt_nx;
            o_req_ready  <= req_ready_nx;
            o_data_byte  <= data_byte_nx;
            o_data_avail <= data_avail_nx;
            o_grant_id   <= grant_id_nx;
            o_active     <= active_nx;
            o_timeout    <= timeout_nx;
`ifdef UART_ARB_TAG_EN
            held_byte    <= held_byte_nx;
            hdr_phase    <= hdr_phase_nx;
`endif
        end
    end

endmodule
